// File: rtl/setting_entry.sv
// Operator-entry stage for the bottling controller: debounces Pulse/QD/CLR,
// edits BCD pill/bottle targets digit by digit, and issues start/reject requests.

module setting_entry_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk_1khz,
  input  logic switch_clr,
  input  logic raw,
  output logic stable
);
  localparam int CW = $clog2(DEB_MS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (raw == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_MS - 1)) begin
      cnt_d    = '0;
      stable_d = raw;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_1khz or posedge switch_clr) begin
    if (switch_clr) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;
endmodule

module setting_entry #(
  parameter int DEB_MS  = 20,
  parameter int LONG_MS = 1000,
  parameter int RPT_DLY = 500,
  parameter int RPT_MS  = 250
) (
  input  logic       clk_1khz,
  input  logic       switch_clr,
  input  logic       enable,
  input  logic       btn_pulse_raw,
  input  logic       btn_qd_raw,
  input  logic       btn_clr,
  output logic [3:0] target_pills1,
  output logic [3:0] target_pills2,
  output logic [3:0] target_pills3,
  output logic [3:0] target_bottles1,
  output logic [3:0] target_bottles2,
  output logic [2:0] sel,
  output logic [5:0] flicker_mask,
  output logic       start_pulse,
  output logic       reject_pulse
);
  localparam int LW = $clog2(LONG_MS + 1);
  localparam int PW = $clog2(RPT_DLY + 1);
  localparam int RW = $clog2(RPT_MS + 1);

  logic p_stable, q_stable, c_stable;
  logic p_prev_q, q_prev_q, c_prev_q, enable_q;
  logic p_rise, q_fall, c_rise, en_fall;

  logic [3:0]    digit_q [5];
  logic [3:0]    digit_d [5];
  logic [2:0]    sel_q, sel_d;
  logic [5:0]    mask_q, mask_d;
  logic          start_q, start_d, reject_q, reject_d;
  logic [LW-1:0] qhold_q, qhold_d;
  logic          qdone_q, qdone_d;
  logic [PW-1:0] phold_q, phold_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          pkill_q, pkill_d;
  logic          rpt_fire, inc, confirm, short_qd, clr_ev, valid;

  setting_entry_debounce #(.DEB_MS(DEB_MS)) u_deb_pulse (
    .clk_1khz(clk_1khz), .switch_clr(switch_clr), .raw(btn_pulse_raw), .stable(p_stable));
  setting_entry_debounce #(.DEB_MS(DEB_MS)) u_deb_qd (
    .clk_1khz(clk_1khz), .switch_clr(switch_clr), .raw(btn_qd_raw), .stable(q_stable));
  setting_entry_debounce #(.DEB_MS(DEB_MS)) u_deb_clr (
    .clk_1khz(clk_1khz), .switch_clr(switch_clr), .raw(btn_clr), .stable(c_stable));

  assign p_rise  = p_stable & ~p_prev_q;
  assign q_fall  = ~q_stable & q_prev_q;
  assign c_rise  = c_stable & ~c_prev_q;
  assign en_fall = enable_q & ~enable;
  assign clr_ev  = c_rise & enable;
  assign valid   = ({digit_q[2], digit_q[1], digit_q[0]} != 12'h000) &&
                   ({digit_q[4], digit_q[3]} != 8'h00);

  // A press is killed for good if it began while disabled or enable dropped during it.
  always_comb begin
    pkill_d  = p_stable & (pkill_q | en_fall | (p_rise & ~enable));
    phold_d  = '0;
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (p_stable) begin
      if (phold_q < PW'(RPT_DLY)) begin
        phold_d = phold_q + 1'b1;
      end else begin
        phold_d  = phold_q;
        rpt_d    = (rpt_q == RW'(RPT_MS - 1)) ? '0 : rpt_q + 1'b1;
        rpt_fire = (rpt_q == '0) & ~pkill_q;
      end
    end
    inc = enable & (p_rise | rpt_fire);
  end

  always_comb begin
    qhold_d  = '0;
    if (q_stable) qhold_d = (qhold_q == LW'(LONG_MS)) ? qhold_q : qhold_q + 1'b1;
    confirm  = q_stable & (qhold_q == LW'(LONG_MS)) & ~qdone_q;
    qdone_d  = q_stable & (qdone_q | confirm | en_fall);
    short_qd = q_fall & ~qdone_q & (qhold_q != LW'(LONG_MS)) & enable;
    start_d  = confirm & enable & valid & ~clr_ev;
    reject_d = confirm & ~(enable & valid) & ~clr_ev;
  end

  always_comb begin
    digit_d = digit_q;
    sel_d   = sel_q;
    if (clr_ev) begin
      for (int i = 0; i < 5; i++) digit_d[i] = 4'd0;
      sel_d = 3'd0;
    end else begin
      if (inc) digit_d[sel_q] = (digit_q[sel_q] == 4'd9) ? 4'd0 : digit_q[sel_q] + 4'd1;
      if (short_qd) sel_d = (sel_q == 3'd4) ? 3'd0 : sel_q + 3'd1;
    end
    mask_d = enable ? (6'b000010 << sel_q) : 6'b000000;
  end

  always_ff @(posedge clk_1khz or posedge switch_clr) begin
    if (switch_clr) begin
      // NOTE: the digit array is five plain registers, not a RAM, so it is reset like any flop.
      for (int i = 0; i < 5; i++) digit_q[i] <= 4'd0;
      sel_q    <= 3'd0;
      mask_q   <= 6'd0;
      start_q  <= 1'b0;
      reject_q <= 1'b0;
      qhold_q  <= '0;
      qdone_q  <= 1'b0;
      phold_q  <= '0;
      rpt_q    <= '0;
      pkill_q  <= 1'b0;
      p_prev_q <= 1'b0;
      q_prev_q <= 1'b0;
      c_prev_q <= 1'b0;
      enable_q <= 1'b0;
    end else begin
      digit_q  <= digit_d;
      sel_q    <= sel_d;
      mask_q   <= mask_d;
      start_q  <= start_d;
      reject_q <= reject_d;
      qhold_q  <= qhold_d;
      qdone_q  <= qdone_d;
      phold_q  <= phold_d;
      rpt_q    <= rpt_d;
      pkill_q  <= pkill_d;
      p_prev_q <= p_stable;
      q_prev_q <= q_stable;
      c_prev_q <= c_stable;
      enable_q <= enable;
    end
  end

  assign target_pills1   = digit_q[0];
  assign target_pills2   = digit_q[1];
  assign target_pills3   = digit_q[2];
  assign target_bottles1 = digit_q[3];
  assign target_bottles2 = digit_q[4];
  assign sel             = sel_q;
  assign flicker_mask    = mask_q;
  assign start_pulse     = start_q;
  assign reject_pulse    = reject_q;
endmodule

// File: tb/tb_setting_entry.sv
// Directed bench for setting_entry: debounce, editing, auto-repeat, confirm/reject, CLR, reset.

module tb_setting_entry;
  localparam int DEB_MS  = 20;
  localparam int LONG_MS = 1000;

  logic       clk_1khz = 1'b0;
  logic       switch_clr, enable, btn_pulse_raw, btn_qd_raw, btn_clr;
  logic [3:0] target_pills1, target_pills2, target_pills3, target_bottles1, target_bottles2;
  logic [2:0] sel;
  logic [5:0] flicker_mask;
  logic       start_pulse, reject_pulse;
  wire [19:0] digits = {target_pills3, target_pills2, target_pills1, target_bottles2, target_bottles1};

  int n_pass = 0, n_total = 0;
  int cyc = 0, start_cnt = 0, reject_cnt = 0, start_cyc = -1, press_edge = 0;
  bit both_seen = 1'b0;

  setting_entry dut (
    .clk_1khz(clk_1khz), .switch_clr(switch_clr), .enable(enable),
    .btn_pulse_raw(btn_pulse_raw), .btn_qd_raw(btn_qd_raw), .btn_clr(btn_clr),
    .target_pills1(target_pills1), .target_pills2(target_pills2), .target_pills3(target_pills3),
    .target_bottles1(target_bottles1), .target_bottles2(target_bottles2),
    .sel(sel), .flicker_mask(flicker_mask), .start_pulse(start_pulse), .reject_pulse(reject_pulse));

  always #5 clk_1khz = ~clk_1khz;
  always @(posedge clk_1khz) cyc++;

  always @(negedge clk_1khz) begin
    if (start_pulse) begin start_cnt++; start_cyc = cyc; end
    if (reject_pulse) reject_cnt++;
    if (start_pulse && reject_pulse) both_seen = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_1khz); #1; end
  endtask

  task automatic press_pulse(input int hold, input int gap);
    btn_pulse_raw = 1'b1; step(hold); btn_pulse_raw = 1'b0; step(gap);
  endtask

  task automatic press_qd(input int hold, input int gap);
    btn_qd_raw = 1'b1; step(hold); btn_qd_raw = 1'b0; step(gap);
  endtask

  task automatic clear_counts();
    start_cnt = 0; reject_cnt = 0; start_cyc = -1;
  endtask

  task automatic test_reset();
    switch_clr = 1'b1; enable = 1'b1;
    btn_pulse_raw = 1'b0; btn_qd_raw = 1'b0; btn_clr = 1'b0;
    step(3);
    n_total++; if (digits !== 20'h0) $display("FAIL reset_digits: got %h want 00000", digits); else n_pass++;
    n_total++; if (sel !== 3'd0) $display("FAIL reset_sel: got %0d want 0", sel); else n_pass++;
    n_total++; if ({flicker_mask, start_pulse, reject_pulse} !== 8'h0)
      $display("FAIL reset_outs: got mask=%b start=%b reject=%b want all 0", flicker_mask, start_pulse, reject_pulse);
    else n_pass++;
    switch_clr = 1'b0;
    step(2);
    n_total++; if (flicker_mask !== 6'b000010) $display("FAIL mask_after_reset: got %b want 000010", flicker_mask); else n_pass++;
  endtask

  task automatic test_pulse_basic();
    btn_pulse_raw = 1'b1;
    step(DEB_MS);
    n_total++; if (target_pills1 !== 4'd0) $display("FAIL pulse_latency_early: got %0d want 0", target_pills1); else n_pass++;
    step(1);
    n_total++; if (target_pills1 !== 4'd1) $display("FAIL pulse_latency_edge: got %0d want 1", target_pills1); else n_pass++;
    step(29); btn_pulse_raw = 1'b0; step(50);
    press_pulse(50, 50);
    press_pulse(50, 50);
    n_total++; if (target_pills1 !== 4'd3) $display("FAIL pulse_three: got %0d want 3", target_pills1); else n_pass++;
    n_total++; if (flicker_mask !== 6'b000010) $display("FAIL pulse_mask: got %b want 000010", flicker_mask); else n_pass++;
  endtask

  task automatic test_glitch();
    press_pulse(10, 40);
    press_pulse(DEB_MS - 1, 40);
    n_total++; if (digits !== 20'h00300) $display("FAIL glitch_ignored: got %h want 00300", digits); else n_pass++;
  endtask

  task automatic test_repeat();
    btn_pulse_raw = 1'b1;
    step(520);
    n_total++; if (target_pills1 !== 4'd4) $display("FAIL rpt_before_dly: got %0d want 4", target_pills1); else n_pass++;
    step(1);
    n_total++; if (target_pills1 !== 4'd5) $display("FAIL rpt_at_dly: got %0d want 5", target_pills1); else n_pass++;
    step(249);
    n_total++; if (target_pills1 !== 4'd5) $display("FAIL rpt_before_period: got %0d want 5", target_pills1); else n_pass++;
    step(1);
    n_total++; if (target_pills1 !== 4'd6) $display("FAIL rpt_at_period: got %0d want 6", target_pills1); else n_pass++;
    step(250);
    n_total++; if (target_pills1 !== 4'd7) $display("FAIL rpt_second_period: got %0d want 7", target_pills1); else n_pass++;
    step(179); btn_pulse_raw = 1'b0; step(50);
    n_total++; if (target_pills1 !== 4'd7) $display("FAIL rpt_release: got %0d want 7", target_pills1); else n_pass++;
    press_pulse(1200, 50);
    n_total++; if (digits !== 20'h00100) $display("FAIL rpt_wrap: got %h want 00100", digits); else n_pass++;
  endtask

  task automatic test_sel_wrap();
    press_qd(100, 50);
    n_total++; if (sel !== 3'd1) $display("FAIL sel_one: got %0d want 1", sel); else n_pass++;
    repeat (9) press_pulse(50, 50);
    n_total++; if (digits !== 20'h09100) $display("FAIL pills2_nine: got %h want 09100", digits); else n_pass++;
    press_pulse(50, 50);
    n_total++; if (digits !== 20'h00100) $display("FAIL pills2_wrap_no_carry: got %h want 00100", digits); else n_pass++;
    press_qd(100, 50);
    n_total++; if (sel !== 3'd2) $display("FAIL sel_two: got %0d want 2", sel); else n_pass++;
    n_total++; if (flicker_mask !== 6'b001000) $display("FAIL sel_two_mask: got %b want 001000", flicker_mask); else n_pass++;
  endtask

  task automatic test_clr_priority();
    press_pulse(50, 50);
    n_total++; if (digits !== 20'h10100) $display("FAIL pills3_one: got %h want 10100", digits); else n_pass++;
    btn_pulse_raw = 1'b1; btn_clr = 1'b1;
    step(50);
    btn_pulse_raw = 1'b0; btn_clr = 1'b0;
    step(50);
    n_total++; if (digits !== 20'h0) $display("FAIL clr_digits: got %h want 00000", digits); else n_pass++;
    n_total++; if (sel !== 3'd0) $display("FAIL clr_sel: got %0d want 0", sel); else n_pass++;
    n_total++; if (flicker_mask !== 6'b000010) $display("FAIL clr_mask: got %b want 000010", flicker_mask); else n_pass++;
  endtask

  task automatic test_confirm();
    press_qd(100, 50); repeat (2) press_pulse(50, 50);
    press_qd(100, 50); press_pulse(50, 50);
    press_qd(100, 50); repeat (5) press_pulse(50, 50);
    n_total++; if (digits !== 20'h12005) $display("FAIL cfg_digits: got %h want 12005", digits); else n_pass++;
    clear_counts();
    btn_qd_raw = 1'b1; press_edge = cyc + 1;
    step(1500); btn_qd_raw = 1'b0; step(50);
    n_total++; if (start_cnt !== 1) $display("FAIL confirm_start_count: got %0d want 1", start_cnt); else n_pass++;
    n_total++; if (reject_cnt !== 0) $display("FAIL confirm_reject_count: got %0d want 0", reject_cnt); else n_pass++;
    n_total++; if (start_cyc - press_edge !== LONG_MS + DEB_MS)
      $display("FAIL confirm_latency: got %0d want %0d", start_cyc - press_edge, LONG_MS + DEB_MS);
    else n_pass++;
    n_total++; if (sel !== 3'd3) $display("FAIL confirm_sel_kept: got %0d want 3", sel); else n_pass++;
  endtask

  task automatic test_reject();
    btn_clr = 1'b1; step(50); btn_clr = 1'b0; step(50);
    clear_counts(); press_qd(1500, 50);
    n_total++; if ({start_cnt, reject_cnt} !== {32'd0, 32'd1})
      $display("FAIL reject_zero: got start=%0d reject=%0d want 0/1", start_cnt, reject_cnt);
    else n_pass++;
    press_pulse(50, 50);
    clear_counts(); press_qd(1500, 50);
    n_total++; if ({start_cnt, reject_cnt} !== {32'd0, 32'd1})
      $display("FAIL reject_no_bottles: got start=%0d reject=%0d want 0/1", start_cnt, reject_cnt);
    else n_pass++;
    repeat (3) press_qd(100, 50);
    press_pulse(50, 50);
    n_total++; if (digits !== 20'h00101) $display("FAIL valid_cfg: got %h want 00101", digits); else n_pass++;
    enable = 1'b0; step(2);
    n_total++; if (flicker_mask !== 6'b000000) $display("FAIL disabled_mask: got %b want 000000", flicker_mask); else n_pass++;
    clear_counts(); press_qd(1500, 50);
    n_total++; if ({start_cnt, reject_cnt} !== {32'd0, 32'd1})
      $display("FAIL reject_disabled: got start=%0d reject=%0d want 0/1", start_cnt, reject_cnt);
    else n_pass++;
    press_pulse(50, 50); press_qd(100, 50);
    btn_clr = 1'b1; step(50); btn_clr = 1'b0; step(50);
    n_total++; if ({digits, sel} !== {20'h00101, 3'd3})
      $display("FAIL disabled_hold: got digits=%h sel=%0d want 00101/3", digits, sel);
    else n_pass++;
    enable = 1'b1; step(2);
  endtask

  task automatic test_enable_drop();
    clear_counts();
    btn_qd_raw = 1'b1; step(500); enable = 1'b0; step(1000); btn_qd_raw = 1'b0; step(50);
    enable = 1'b1; step(2);
    n_total++; if ({start_cnt, reject_cnt, 29'd0, sel} !== {32'd0, 32'd0, 32'd3})
      $display("FAIL enable_drop_silent: got start=%0d reject=%0d sel=%0d want 0/0/3", start_cnt, reject_cnt, sel);
    else n_pass++;
    clear_counts(); press_qd(1500, 50);
    n_total++; if ({start_cnt, reject_cnt} !== {32'd1, 32'd0})
      $display("FAIL next_press_start: got start=%0d reject=%0d want 1/0", start_cnt, reject_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_press();
    clear_counts();
    btn_qd_raw = 1'b1; step(600);
    switch_clr = 1'b1; step(3);
    n_total++; if ({digits, sel, flicker_mask} !== 29'd0)
      $display("FAIL midreset_outs: got digits=%h sel=%0d mask=%b want 0", digits, sel, flicker_mask);
    else n_pass++;
    btn_qd_raw = 1'b0; step(2); switch_clr = 1'b0; step(1100);
    n_total++; if ({start_cnt, reject_cnt} !== {32'd0, 32'd0})
      $display("FAIL midreset_no_pulse: got start=%0d reject=%0d want 0/0", start_cnt, reject_cnt);
    else n_pass++;
    btn_pulse_raw = 1'b1; step(30);
    switch_clr = 1'b1; step(3); switch_clr = 1'b0;
    step(DEB_MS);
    n_total++; if (target_pills1 !== 4'd0) $display("FAIL afresh_early: got %0d want 0", target_pills1); else n_pass++;
    step(1);
    n_total++; if (target_pills1 !== 4'd1) $display("FAIL afresh_edge: got %0d want 1", target_pills1); else n_pass++;
    btn_pulse_raw = 1'b0; step(50);
  endtask

  initial begin
    test_reset();
    test_pulse_basic();
    test_glitch();
    test_repeat();
    test_sel_wrap();
    test_clr_priority();
    test_confirm();
    test_reject();
    test_enable_drop();
    test_reset_mid_press();
    n_total++; if (both_seen !== 1'b0) $display("FAIL start_reject_overlap: got %b want 0", both_seen); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
